// File: rtl/sipo_deframer.sv
// sipo_deframer: MSB-first serial-to-parallel deframer with start marker and one-word output buffer
module sipo_deframer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         ser_in,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         busy,
    output logic         frame_err,
    output logic         overrun
);
    localparam int CW = $clog2(N);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [N-2:0]  sreg;
    logic [CW-1:0] cnt;
    logic [N-1:0]  word;
    logic          last, complete, accept;

    assign word     = {sreg, ser_in};
    assign last     = cnt == CW'(N - 1);
    assign complete = state == SHIFT && !start && last;
    assign accept   = complete && (!data_valid || out_ready);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: a start always (re)enters SHIFT, the final bit returns to IDLE
    always_comb begin
        state_nxt = state;
        if (start)         state_nxt = SHIFT;
        else if (complete) state_nxt = IDLE;
    end

    // busy mirrors the SHIFT state
    always_comb begin
        busy = state == SHIFT;
    end

    // shift register and bit counter; idle cycles without start leave them untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (start) begin
            sreg <= (N-1)'(ser_in);
            cnt  <= CW'(1);
        end else if (state == SHIFT) begin
            sreg <= complete ? sreg : word[N-2:0];
            cnt  <= complete ? '0 : cnt + CW'(1);
        end
    end

    // output buffer: a completed word is taken if the buffer is empty or drained on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (accept) begin
            data_out   <= word;
            data_valid <= 1'b1;
        end else if (data_valid && out_ready) begin
            data_valid <= 1'b0;
        end
    end

    // one-cycle error pulses: abandoned partial word, dropped completed word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= state == SHIFT && start;
            overrun   <= complete && data_valid && !out_ready;
        end
    end
endmodule

// File: tb/tb_sipo_deframer.sv
// tb_sipo_deframer: directed scoreboard bench for sipo_deframer with N=8
module tb_sipo_deframer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       ser_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, busy, frame_err, overrun;

    int         checks = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    sipo_deframer #(.N(8)) dut (
        .clk(clk), .reset(reset), .start(start), .ser_in(ser_in),
        .out_ready(out_ready), .data_out(data_out), .data_valid(data_valid),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input logic st, input logic d, input logic rdy);
        start = st;
        ser_in = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < 8; i++) cyc(i == 0, w[7-i], rdy);
        start = 1'b0;
    endtask

    // monitor: every newly presented word is popped from the scoreboard and compared
    initial begin
        logic       prev_v;
        logic [7:0] prev_d;
        prev_v = 1'b0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            if (reset && data_valid && (!prev_v || data_out !== prev_d)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL word: unexpected %0h with empty scoreboard at %0t", data_out, $time);
                end else begin
                    chk("word", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            prev_v = data_valid;
            prev_d = data_out;
        end
    end

    initial begin
        logic [7:0] w;
        #2;
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({frame_err, overrun}), 0);
        #5 reset = 1'b1;
        cyc(0, 1, 0);
        chk("idle_busy", 32'(busy), 0);

        // first word AB, busy only while bits are outstanding
        w = 8'hAB;
        exp_q.push_back(w);
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, w[7-i], 0);
            chk($sformatf("busy_ab_%0d", i), 32'(busy), 32'(i < 7));
        end
        start = 1'b0;
        chk("ab_valid", 32'(data_valid), 1);
        chk("ab_data", 32'(data_out), 32'hAB);

        // 3C dropped while AB still unconsumed
        send(8'h3C, 0);
        chk("ovr_pulse", 32'(overrun), 1);
        chk("ovr_hold", 32'(data_out), 32'hAB);
        cyc(0, 0, 1);
        chk("ovr_clear", 32'(overrun), 0);
        chk("consume_valid", 32'(data_valid), 0);

        // back-to-back 55 then F0 with out_ready held
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hF0);
        send(8'h55, 1);
        chk("b2b_55_valid", 32'(data_valid), 1);
        chk("b2b_55_ovr", 32'(overrun), 0);
        cyc(1, 1, 1);
        chk("b2b_nogap_busy", 32'(busy), 1);
        w = 8'hF0;
        for (int i = 1; i < 8; i++) cyc(0, w[7-i], 1);
        chk("b2b_f0_data", 32'(data_out), 32'hF0);
        chk("b2b_f0_ovr", 32'(overrun), 0);
        cyc(0, 0, 1);
        chk("b2b_drain", 32'(data_valid), 0);

        // restart on the 4th bit, then 81
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        w = 8'h81;
        exp_q.push_back(w);
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, w[7-i], 0);
            if (i == 0) chk("ferr_pulse", 32'(frame_err), 1);
            if (i == 1) chk("ferr_clear", 32'(frame_err), 0);
        end
        start = 1'b0;
        chk("ferr_data", 32'(data_out), 32'h81);
        chk("ferr_valid", 32'(data_valid), 1);

        // async reset during bit 5 with 81 still buffered
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_data", 32'(data_out), 0);
        chk("arst_valid", 32'(data_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_flags", 32'({frame_err, overrun}), 0);
        #2 reset = 1'b1;
        exp_q.push_back(8'hC3);
        send(8'hC3, 0);
        chk("c3_data", 32'(data_out), 32'hC3);
        chk("c3_flags", 32'({frame_err, overrun}), 0);
        cyc(0, 0, 1);

        // completion and drain on the same edge: 12 replaced by 34
        exp_q.push_back(8'h12);
        send(8'h12, 0);
        w = 8'h34;
        exp_q.push_back(w);
        for (int i = 0; i < 8; i++) cyc(i == 0, w[7-i], i == 7);
        start = 1'b0;
        chk("same_edge_data", 32'(data_out), 32'h34);
        chk("same_edge_valid", 32'(data_valid), 1);
        chk("same_edge_ovr", 32'(overrun), 0);
        cyc(0, 0, 1);
        repeat (3) cyc(0, 0, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 Parameter N, default 8, word width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-004 start  input  1  frame marker; 1 means ser_in this cycle is the MSB of a new word.
REQ-005 ser_in  input  1  serial data, MSB first, one bit per clock.
REQ-006 out_ready  input  1  consumer accepts data_out at a rising edge where data_valid=1 and out_ready=1.
REQ-007 data_out  output  N  last completed word, registered.
REQ-008 data_valid  output  1  data_out holds an unconsumed word.
REQ-009 busy  output  1  high while a word is partially received (state SHIFT).
REQ-010 frame_err  output  1  one-cycle pulse: partial word abandoned by a new start.
REQ-011 overrun  output  1  one-cycle pulse: completed word dropped because the output was full.

Function
REQ-012 FSM states: IDLE and SHIFT; internal shift register sreg[N-2:0]; bit counter cnt, width clog2(N).
REQ-013 IDLE, start=0: ser_in ignored; state, sreg and cnt unchanged.
REQ-014 IDLE, start=1: sreg[0]<=ser_in, cnt<=1, next state SHIFT.
REQ-015 SHIFT, start=0, cnt<N-1: sreg<={sreg[N-3:0],ser_in}, cnt<=cnt+1.
REQ-016 SHIFT, start=0, cnt=N-1: word W={sreg[N-2:0],ser_in} completes at this edge; next state IDLE, cnt<=0.
REQ-017 Latency: if the start bit is sampled at edge E0, W is on data_out and data_valid=1 immediately after edge E(N-1).
REQ-018 On completion with data_valid=0: data_out<=W, data_valid<=1.
REQ-019 On completion with data_valid=1 and out_ready=1: data_out<=W, data_valid stays 1, no overrun.
REQ-020 On completion with data_valid=1 and out_ready=0: W discarded, data_out unchanged, overrun=1 for one cycle.
REQ-021 Without completion, data_valid=1 and out_ready=1 at an edge: data_valid<=0; data_out holds its value.
REQ-022 data_out and data_valid change only as given in REQ-018..021; out_ready while data_valid=0 has no effect.
REQ-023 SHIFT, start=1 at any cnt, including cnt=N-1: partial word abandoned, frame_err=1 for one cycle, restart exactly as REQ-014; state stays SHIFT; no completion this cycle.
REQ-024 Back-to-back: start may be 1 on the cycle immediately after completion (state IDLE); no dead cycle.
REQ-025 busy=1 exactly when state=SHIFT; frame_err and overrun are registered and never high for two consecutive cycles from a single event.

Reset
REQ-026 reset=0 forces: state IDLE, cnt=0, sreg=0, data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0.
REQ-027 reset asserted mid-word discards the partial word with no frame_err; after release the block waits in IDLE for start.
REQ-028 First capture after release occurs at the first rising edge with reset=1 and start=1.

Verification (N=8)
REQ-029 Reset release, start pulse with serial 1,0,1,0,1,0,1,1 on consecutive cycles, out_ready=0 -> after 8th edge data_out=8'hAB, data_valid=1; busy high for edges 1..7 only.
REQ-030 Hold 8'hAB unconsumed, send 8'h3C -> overrun pulses one cycle at completion; data_out stays 8'hAB; then out_ready=1 for one edge -> data_valid=0.
REQ-031 Send 8'h55 with out_ready held 1 and second word 8'hF0 started on the next cycle -> data_out=8'h55 then 8'hF0, no gap cycle, no overrun.
REQ-032 start re-asserted at 4th bit of a word, then 8 new bits 8'h81 -> frame_err one-cycle pulse; data_out=8'h81 eight edges after the second start.
REQ-033 reset=0 asynchronously between edges during bit 5 -> all outputs 0 immediately; next full frame 8'hC3 received correctly.
REQ-034 Completion and out_ready=1 on the same edge with data_valid=1 (old 8'h12, new 8'h34) -> data_out=8'h34, data_valid=1, overrun=0.
